// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch
// Description : Decode/operand-read stage with writeback bypass, destination
//               scoreboard (RAW/WAW stall) and a valid/ready register to EX.
//               Optional stall counter: define OPERAND_FETCH_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_instr,
    input  logic [XLEN-1:0]   in_pc,
    output logic [REG_AW-1:0] rf_rd_addr_1,
    output logic [REG_AW-1:0] rf_rd_addr_2,
    input  logic [XLEN-1:0]   rf_data_1,
    input  logic [XLEN-1:0]   rf_data_2,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_instr,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_rs1_data,
    output logic [XLEN-1:0]   out_rs2_data,
    output logic [REG_AW-1:0] out_rd_addr,
    output logic              out_rd_wen
`ifdef OPERAND_FETCH_STALL_CNT_EN
    ,
    output logic [XLEN-1:0]   perf_stall_cnt
`endif
);

    localparam int NREG = 1 << REG_AW;
    localparam logic [NREG-1:0] ONE = NREG'(1);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [6:0]        opcode;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              rd_used;
    logic              rs1_used;
    logic              rs2_used;
    logic              writes_rd;

    logic [NREG-1:0]   scoreboard;
    logic [NREG-1:0]   held_mask;
    logic [NREG-1:0]   wb_mask;
    logic [NREG-1:0]   set_mask;
    logic [NREG-1:0]   blocked;
    logic              hazard;
    logic              accept;
    logic              issue;
    logic [XLEN-1:0]   operand_1;
    logic [XLEN-1:0]   operand_2;

    assign opcode       = in_instr[6:0];
    assign rd           = in_instr[7 +: REG_AW];
    assign rs1          = in_instr[15 +: REG_AW];
    assign rs2          = in_instr[20 +: REG_AW];
    assign rf_rd_addr_1 = rs1;
    assign rf_rd_addr_2 = rs2;

    always_comb begin
        rd_used  = 1'b0;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL: rd_used = 1'b1;
            OP_JALR, OP_LOAD, OP_IMM: begin
                rd_used  = 1'b1;
                rs1_used = 1'b1;
            end
            OP_BRANCH, OP_STORE: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            OP_REG: begin
                rd_used  = 1'b1;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            default: ;
        endcase
    end

    assign writes_rd = rd_used && (rd != '0);

    // A register is unavailable if the held entry will write it, or if it is
    // pending in the scoreboard and not being written back right now.
    assign held_mask = (out_valid && out_rd_wen) ? (ONE << out_rd_addr) : '0;
    assign wb_mask   = (wb_en && (wb_addr != '0)) ? (ONE << wb_addr) : '0;
    assign blocked   = (held_mask | (scoreboard & ~wb_mask)) & ~ONE;

    assign hazard = (rs1_used  && blocked[rs1]) ||
                    (rs2_used  && blocked[rs2]) ||
                    (writes_rd && blocked[rd]);

    assign in_ready = !rst && !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign issue    = out_valid && out_ready && out_rd_wen && !flush;
    assign set_mask = issue ? (ONE << out_rd_addr) : '0;

    always_comb begin
        operand_1 = rf_data_1;
        operand_2 = rf_data_2;
        if (rs1 == '0)
            operand_1 = '0;
        else if (wb_en && (wb_addr == rs1))
            operand_1 = wb_data;
        if (rs2 == '0)
            operand_2 = '0;
        else if (wb_en && (wb_addr == rs2))
            operand_2 = wb_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_instr    <= '0;
            out_pc       <= '0;
            out_rs1_data <= '0;
            out_rs2_data <= '0;
            out_rd_addr  <= '0;
            out_rd_wen   <= 1'b0;
            scoreboard   <= '0;
        end else begin
            if (accept) begin
                out_valid    <= 1'b1;
                out_instr    <= in_instr;
                out_pc       <= in_pc;
                out_rs1_data <= operand_1;
                out_rs2_data <= operand_2;
                out_rd_addr  <= writes_rd ? rd : '0;
                out_rd_wen   <= writes_rd;
            end else if (out_ready || flush) begin
                out_valid    <= 1'b0;
            end
            // Set is applied after clear so a same-cycle set wins.
            scoreboard <= (scoreboard & ~wb_mask) | set_mask;
        end
    end

`ifdef OPERAND_FETCH_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            perf_stall_cnt <= '0;
        else if (in_valid && hazard && !flush && (perf_stall_cnt != '1))
            perf_stall_cnt <= perf_stall_cnt + 1'b1;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_fetch
// Description : Randomized self-checking bench for operand_fetch against a
//               set-based reference model with an in-order writeback queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_fetch;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int CYCLES = 4000;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_instr;
    logic [XLEN-1:0]   in_pc;
    logic [REG_AW-1:0] rf_rd_addr_1;
    logic [REG_AW-1:0] rf_rd_addr_2;
    logic [XLEN-1:0]   rf_data_1;
    logic [XLEN-1:0]   rf_data_2;
    logic              wb_en;
    logic [REG_AW-1:0] wb_addr;
    logic [XLEN-1:0]   wb_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_instr;
    logic [XLEN-1:0]   out_pc;
    logic [XLEN-1:0]   out_rs1_data;
    logic [XLEN-1:0]   out_rs2_data;
    logic [REG_AW-1:0] out_rd_addr;
    logic              out_rd_wen;
`ifdef OPERAND_FETCH_STALL_CNT_EN
    logic [XLEN-1:0]   perf_stall_cnt;
`endif

    operand_fetch #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .rf_rd_addr_1 (rf_rd_addr_1),
        .rf_rd_addr_2 (rf_rd_addr_2),
        .rf_data_1    (rf_data_1),
        .rf_data_2    (rf_data_2),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_rs1_data (out_rs1_data),
        .out_rs2_data (out_rs2_data),
        .out_rd_addr  (out_rd_addr),
        .out_rd_wen   (out_rd_wen)
`ifdef OPERAND_FETCH_STALL_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Environment register file, read combinationally at the DUT's addresses.
    logic [XLEN-1:0] rf [32];
    assign rf_data_1 = rf[rf_rd_addr_1];
    assign rf_data_2 = rf[rf_rd_addr_2];

    // Reference model state.
    bit              m_valid;
    logic [XLEN-1:0] m_instr, m_pc, m_rs1, m_rs2;
    int              m_rd;
    bit              m_wen;
    bit              pending [32];
    int              wb_queue [$];
    logic [XLEN-1:0] m_cnt;

    int checks = 0;
    int errors = 0;

    logic [6:0] ops [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                             7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
                             7'b0110011, 7'b1110011};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit op_writes(input logic [6:0] op);
        return op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                          7'b0000011, 7'b0010011, 7'b0110011};
    endfunction

    function automatic bit op_reads1(input logic [6:0] op);
        return op inside {7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011,
                          7'b0010011, 7'b0110011};
    endfunction

    function automatic bit op_reads2(input logic [6:0] op);
        return op inside {7'b1100011, 7'b0100011, 7'b0110011};
    endfunction

    function automatic bit unavailable(input int r);
        if (r == 0) return 1'b0;
        if (m_valid && m_wen && m_rd == r) return 1'b1;
        return pending[r] && !(wb_en && int'(wb_addr) == r);
    endfunction

    function automatic logic [XLEN-1:0] value_of(input int r);
        if (r == 0) return '0;
        if (wb_en && int'(wb_addr) == r) return wb_data;
        return rf[r];
    endfunction

    initial begin
        int              op_i, rd, rs1, rs2, r;
        bit              hz, exp_ready, accept, issue, pop;
        bit              rf_wr;
        int              rf_wr_addr;
        logic [XLEN-1:0] rf_wr_data;
        logic [XLEN-1:0] instr;
        int              ready_pct;

        for (int i = 0; i < 32; i++) begin
            rf[i]      = (i == 0) ? '0 : $urandom();
            pending[i] = 1'b0;
        end
        m_valid = 1'b0; m_instr = '0; m_pc = '0; m_rs1 = '0; m_rs2 = '0;
        m_rd = 0; m_wen = 1'b0; m_cnt = '0;
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0; out_ready = 1'b0;

        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            #1;
            check("reset_in_ready", in_ready, 1'b0);
            @(posedge clk); #1;
            check("reset_out_valid", out_valid, 1'b0);
            check("reset_out_instr", out_instr, '0);
            check("reset_out_rs1", out_rs1_data, '0);
            check("reset_out_rd_wen", out_rd_wen, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int c = 0; c < CYCLES; c++) begin
            ready_pct = (c < CYCLES / 3) ? 90 : ((c < 2 * CYCLES / 3) ? 40 : 100);
            if (c != 0) @(negedge clk);

            op_i  = $urandom_range(0, 9);
            rd    = $urandom_range(0, 7);
            rs1   = $urandom_range(0, 7);
            rs2   = $urandom_range(0, 7);
            instr = $urandom();
            instr[6:0]   = ops[op_i];
            instr[11:7]  = rd[4:0];
            instr[19:15] = rs1[4:0];
            instr[24:20] = rs2[4:0];
            in_instr  = instr;
            in_pc     = $urandom();
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(1, 100) <= ready_pct;
            flush     = $urandom_range(0, 19) == 0;

            pop   = 1'b0;
            wb_en = 1'b0;
            wb_addr = '0;
            wb_data = $urandom();
            if (wb_queue.size() > 0 && $urandom_range(0, 2) != 0) begin
                wb_en   = 1'b1;
                wb_addr = wb_queue[0][4:0];
                pop     = 1'b1;
            end else if ($urandom_range(0, 3) == 0) begin
                r = $urandom_range(0, 7);
                if (!pending[r]) begin
                    wb_en   = 1'b1;
                    wb_addr = r[4:0];
                end
            end
            #1;

            hz = (op_reads1(ops[op_i]) && unavailable(rs1)) ||
                 (op_reads2(ops[op_i]) && unavailable(rs2)) ||
                 (op_writes(ops[op_i]) && rd != 0 && unavailable(rd));
            exp_ready = !flush && !hz && (!m_valid || out_ready);
            check("in_ready", in_ready, exp_ready);
            check("rf_rd_addr_1", rf_rd_addr_1, rs1[4:0]);
            check("rf_rd_addr_2", rf_rd_addr_2, rs2[4:0]);

            accept = in_valid && exp_ready;
            issue  = m_valid && out_ready && m_wen && !flush;

            if (in_valid && hz && !flush && m_cnt != '1) m_cnt++;
            if (wb_en && wb_addr != 0) pending[wb_addr] = 1'b0;
            if (issue) begin
                pending[m_rd] = 1'b1;
                wb_queue.push_back(m_rd);
            end
            if (pop) void'(wb_queue.pop_front());

            if (accept) begin
                m_valid = 1'b1;
                m_instr = in_instr;
                m_pc    = in_pc;
                m_rs1   = value_of(rs1);
                m_rs2   = value_of(rs2);
                m_wen   = op_writes(ops[op_i]) && rd != 0;
                m_rd    = m_wen ? rd : 0;
            end else if (out_ready || flush) begin
                m_valid = 1'b0;
            end

            rf_wr      = wb_en && wb_addr != 0;
            rf_wr_addr = int'(wb_addr);
            rf_wr_data = wb_data;

            @(posedge clk); #1;
            if (rf_wr) rf[rf_wr_addr] = rf_wr_data;

            check("out_valid", out_valid, m_valid);
            if (m_valid) begin
                check("out_instr", out_instr, m_instr);
                check("out_pc", out_pc, m_pc);
                check("out_rs1_data", out_rs1_data, m_rs1);
                check("out_rs2_data", out_rs2_data, m_rs2);
                check("out_rd_addr", out_rd_addr, m_rd[4:0]);
                check("out_rd_wen", out_rd_wen, m_wen);
            end
`ifdef OPERAND_FETCH_STALL_CNT_EN
            check("perf_stall_cnt", perf_stall_cnt, m_cnt);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
